mbist_addr_seq: RTL
===================

Name: mbist_addr_seq

Overview:
Parametrised address sequencer for the MBIST engine; successor to the fixed-width up/down address counter.
- Walks an arbitrary depth, either ascending or descending, one address per accepted step.
- Flags the final address, pulses done at sequence end and supports abort.
- Sits between the march-element FSM (drives start/step) and the memory-under-test address mux.

Parameters:
ADDR_W, 12, address width in bits (>=2)
DEPTH, 4096, number of words walked; 2 <= DEPTH <= 2**ADDR_W; need not be a power of two
COL_W, 4, column-field width used only by the optional row-fast mode; 1 <= COL_W < ADDR_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin a sequence; sampled only in IDLE
dir_up  in  1  direction, latched on accepted start: 1 = 0..DEPTH-1, 0 = DEPTH-1..0
step  in  1  advance request; honoured only in RUN
abort  in  1  terminate sequence immediately
addr  out  ADDR_W  current address
busy  out  1  high in RUN
last  out  1  high in RUN while addr is the final address of the sequence
done  out  1  one-cycle pulse after the final address is stepped
pass_cnt  out  8  completed-sequence count, saturating at 255

Behaviour:
- States: IDLE, RUN.
- Reset values: state IDLE, addr 0, busy 0, last 0, done 0, pass_cnt 0, latched dir 1.
- IDLE, start=1: latch dir_up, load addr (0 if up, DEPTH-1 if down), go to RUN next cycle. The first address is visible in the same cycle busy rises.
- RUN, step=1, not last: addr +1 (up) or -1 (down), modulo-free.
- RUN, step=1, last=1:
  - return to IDLE with addr 0;
  - pulse done for one cycle;
  - increment pass_cnt unless it is already 255.
- RUN, step=0: hold addr.
- last is combinational from registered state. Up: addr==DEPTH-1. Down: addr==0.
- Latency: addr updates one cycle after step. done is high the cycle after the final step, concurrent with busy=0.
- abort in RUN: next cycle IDLE, addr 0, no done, pass_cnt unchanged. abort has priority over step.
- abort in IDLE: no effect.
- start in RUN: ignored.
- start in the cycle done is high: accepted; back-to-back sequences need no idle gap beyond the done cycle.
- Counter arithmetic is ADDR_W bits; DEPTH-1 comparisons use ADDR_W-bit constants. addr never leaves [0, DEPTH-1] and never wraps.
- rst has priority over everything, including mid-sequence; all outputs return to reset values on the next edge.

Optional Feature:
Macro MBIST_ADDR_ROWFAST_EN.
- Defined: addr = {cnt[COL_W-1:0], cnt[ADDR_W-1:COL_W]}, where cnt is the internal linear counter. Row field varies fastest, column field slowest. last/done still derive from cnt.
  - Legal only when DEPTH == 2**ADDR_W.
  - Otherwise elaboration must fail via a generate-time error.
- Undefined: addr = cnt. COL_W is unused.

Decomposition:
- Shared package mbist_pkg holds:
  - state encoding typedef (IDLE/RUN);
  - pass counter width constant (8);
  - saturation limit (255).
- One sub-module, mbist_addr_cnt: ADDR_W-bit loadable up/down counter with load, load_val, en, up and clr inputs.
  - mbist_addr_seq contains the FSM, last/done logic, pass counter and optional bit swizzle.

Test Plan:
- ADDR_W=4, DEPTH=10, start with dir_up=1, step every cycle -> addr 0..9, last only at 9, done the cycle after step at 9, pass_cnt=1, addr returns to 0.
- Same parameters, dir_up=0, step every other cycle -> addr 9,9,8,8..0 with each value held while step=0; done once; no underflow past 0.
- Abort at addr=5 while step=1 -> next cycle busy=0, addr=0, done=0, pass_cnt unchanged; a subsequent start restarts at 0.
- start asserted in the done cycle, repeated 260 times -> each sequence starts without a gap; pass_cnt saturates at 255.
- rst asserted at addr=7 mid-RUN together with step -> next cycle all outputs at reset values; start and step ignored while rst=1.
- MBIST_ADDR_ROWFAST_EN defined, ADDR_W=4, DEPTH=16, COL_W=2, up -> addr sequence 0,4,8,12,1,5,9,13,... ending at 15; done after 16 steps.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST address sequencer: FSM state encoding
// and pass-counter sizing.
package mbist_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned PassCntW = 8;
  localparam logic [PassCntW-1:0] PassCntMax = 8'd255;

endpackage

// File: rtl/mbist_addr_cnt.sv
// Loadable up/down address counter. clr beats load, load beats en.
module mbist_addr_cnt #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] cnt
);

  logic [ADDR_W-1:0] cnt_q;

  // Counter register with synchronous reset/clear, load and count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= up ? cnt_q + ADDR_W'(1) : cnt_q - ADDR_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mbist_addr_seq.sv
// MBIST address sequencer: walks DEPTH addresses up or down, one per step,
// flags the final address, pulses done at the end and counts passes.
// Optional build macro MBIST_ADDR_ROWFAST_EN swaps the column and row
// fields of the output address (requires DEPTH == 2**ADDR_W).
module mbist_addr_seq
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned COL_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir_up,
  input  logic                step,
  input  logic                abort,
  output logic [ADDR_W-1:0]   addr,
  output logic                busy,
  output logic                last,
  output logic                done,
  output logic [PassCntW-1:0] pass_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  // Parameter legality, checked in every build.
  if (ADDR_W < 2 || DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("mbist_addr_seq: illegal ADDR_W/DEPTH combination");
  end
  if (COL_W < 1 || COL_W >= ADDR_W) begin : g_bad_col
    $error("mbist_addr_seq: COL_W must be in [1, ADDR_W-1]");
  end

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic [PassCntW-1:0]   pass_q, pass_d;
  logic                  cnt_clr, cnt_load, cnt_en;
  logic [ADDR_W-1:0]     cnt_load_val;
  logic [ADDR_W-1:0]     cnt;

  mbist_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .up       (dir_q),
    .cnt      (cnt)
  );

  // Final address of the sequence, derived from the linear counter.
  always_comb begin
    last = 1'b0;
    if (state_q == StRun) begin
      last = dir_q ? (cnt == LastAddr) : (cnt == '0);
    end
  end

  // Next-state, counter control, done pulse and saturating pass count.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          dir_d        = dir_up;
          cnt_load     = 1'b1;
          cnt_load_val = dir_up ? '0 : LastAddr;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else if (step) begin
          if (last) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
            done_d  = 1'b1;
            pass_d  = (pass_q == PassCntMax) ? pass_q : pass_q + 8'd1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign pass_cnt = pass_q;

`ifdef MBIST_ADDR_ROWFAST_EN
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_rowfast
    $error("mbist_addr_seq: row-fast mode needs DEPTH == 2**ADDR_W");
  end
  // Low counter bits become the row field so rows change fastest.
  assign addr = {cnt[COL_W-1:0], cnt[ADDR_W-1:COL_W]};
`else
  assign addr = cnt;
`endif

endmodule
